// File: rtl/rom_loader_pkg.sv
// Shared types and defaults for the ROM download mapper: write FSM states,
// the buffered write entry and the default slot-to-bank map.
package rom_loader_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } wr_state_t;

    // Entries carry a fixed-width address; only the low RAM_AW bits are used.
    localparam int ENTRY_AW = 32;

    typedef struct packed {
        logic [ENTRY_AW-1:0] addr;
        logic [7:0]          data;
    } rom_entry_t;

    localparam logic [26:0] DEFAULT_SLOT_BANKS = {9'h107, 9'h100, 9'h000};

endpackage

// File: rtl/rom_loader_fifo.sv
// Small synchronous FIFO with full/empty flags; a push into a full FIFO is
// accepted when a pop happens in the same cycle. DEPTH must be a power of two.
module rom_loader_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/rom_loader.sv
// ROM download mapper: ioctl bytes -> per-slot SDRAM bank writes via a FIFO,
// with load tracking and CPU read mask. ROM_LOADER_CHECKSUM_EN adds csum.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int                                SLOTS        = 3,
    parameter int                                SLOT_AW      = 14,
    parameter int                                RAM_AW       = 23,
    parameter logic [SLOTS*(RAM_AW-SLOT_AW)-1:0] SLOT_BANKS   = DEFAULT_SLOT_BANKS,
    parameter logic [RAM_AW-SLOT_AW-1:0]         RAM_BANK_TOP = 9'h100,
    parameter logic [7:0]                        INDEX        = 8'd0,
    parameter int                                FIFO_DEPTH   = 4
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_a,
    output logic [7:0]        ram_din,
    input  logic              ram_ack,
    output logic              busy,
    output logic [SLOTS-1:0]  loaded,
    input  logic [RAM_AW-1:0] q_a,
    output logic [7:0]        rom_mask,
    output logic              err_range,
    output logic              err_overrun
`ifdef ROM_LOADER_CHECKSUM_EN
    ,
    output logic [SLOTS*8-1:0] csum
`endif
);

    localparam int BW = RAM_AW - SLOT_AW;
    localparam int SW = 25 - SLOT_AW;

    logic             active, active_q, active_rise, strobe;
    logic [SW-1:0]    wr_slot;
    logic             slot_ok;
    logic [BW-1:0]    wr_bank;
    rom_entry_t       push_entry, head;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic             range_set, overrun_set, ack_fire;
    logic [SLOTS-1:0] ack_hit;
    logic [BW-1:0]    q_bank;
    logic             q_readable;
    wr_state_t        state, state_next;
    logic             unused_bits;

    assign active      = ioctl_download && (ioctl_index == INDEX);
    assign active_rise = active && !active_q;
    assign strobe      = ioctl_wr && active;
    assign wr_slot     = ioctl_addr[24:SLOT_AW];
    assign slot_ok     = (wr_slot < SW'(SLOTS));
    assign range_set   = strobe && !slot_ok;
    // A full FIFO still takes the byte when the write side pops this cycle.
    assign fifo_push   = strobe && slot_ok && (!fifo_full || fifo_pop);
    assign overrun_set = strobe && slot_ok && fifo_full && !fifo_pop;
    assign unused_bits = ^{q_a[SLOT_AW-1:0], head.addr[ENTRY_AW-1:RAM_AW]};

    always_comb begin
        wr_bank = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (wr_slot == SW'(i)) wr_bank = SLOT_BANKS[i*BW +: BW];
        end
    end

    always_comb begin
        push_entry                   = '0;
        push_entry.addr[RAM_AW-1:0]  = {wr_bank, ioctl_addr[SLOT_AW-1:0]};
        push_entry.data              = ioctl_dout;
    end

    rom_loader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(rom_entry_t))
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .push    (fifo_push),
        .din     (push_entry),
        .pop     (fifo_pop),
        .dout    (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!fifo_empty) state_next = WAIT;
            WAIT:    if (ram_ack && fifo_empty) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        fifo_pop = 1'b0;
        ack_fire = 1'b0;
        case (state)
            IDLE: fifo_pop = !fifo_empty;
            WAIT: begin
                ack_fire = ram_ack;
                fifo_pop = ram_ack && !fifo_empty;
            end
            default: ;
        endcase
    end

    // ram_we is the WAIT state itself, so reset removes it asynchronously.
    assign ram_we = (state == WAIT);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ram_a   <= '0;
            ram_din <= '0;
        end else if (fifo_pop) begin
            ram_a   <= head.addr[RAM_AW-1:0];
            ram_din <= head.data;
        end
    end

    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            ack_hit[i] = ack_fire && (ram_a[RAM_AW-1:SLOT_AW] == SLOT_BANKS[i*BW +: BW]);
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            active_q    <= 1'b0;
            loaded      <= '0;
            err_range   <= 1'b0;
            err_overrun <= 1'b0;
            busy        <= 1'b0;
        end else begin
            active_q    <= active;
            loaded      <= active_rise ? '0 : (loaded | ack_hit);
            err_range   <= range_set   | (err_range   && !active_rise);
            err_overrun <= overrun_set | (err_overrun && !active_rise);
            busy        <= active | !fifo_empty | ram_we;
        end
    end

    assign q_bank = q_a[RAM_AW-1:SLOT_AW];

    always_comb begin
        q_readable = (q_bank < RAM_BANK_TOP);
        for (int i = 0; i < SLOTS; i++) begin
            if (loaded[i] && q_bank == SLOT_BANKS[i*BW +: BW]) q_readable = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) rom_mask <= 8'hFF;
        else          rom_mask <= q_readable ? 8'h00 : 8'hFF;
    end

`ifdef ROM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            csum <= '0;
        end else if (active_rise) begin
            csum <= '0;
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (ack_hit[i]) csum[i*8 +: 8] <= csum[i*8 +: 8] + ram_din;
            end
        end
    end
`endif

endmodule
